dram_perf_gen: RTL and testbench

DRAM_PERF_GEN -- requirements
Module: dram_perf_gen

---
 rtl/dram_perf_gen.sv | 217 +++++++++++++++++++++
 tb/tb_dram_perf_gen.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_perf_gen.sv
// DRAM performance/traffic generator: issues AXI4 write and/or read bursts,
// measures phase durations and worst-case read latency, and signs read data.
module dram_perf_gen #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 32,
  parameter int LAT_W           = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [63:0]        start_addr,
  input  logic [7:0]         burst_len,
  input  logic [15:0]        num_bursts,
  input  logic [31:0]        write_val,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [31:0]        rd_hash,
  output logic [CNT_W-1:0]   rd_cycles,
  output logic [CNT_W-1:0]   wr_cycles,
  output logic [LAT_W-1:0]   max_rd_lat,
  // AXI4 master: write address
  output logic [15:0]        awid,
  output logic [63:0]        awaddr,
  output logic [7:0]         awlen,
  output logic [2:0]         awsize,
  output logic [1:0]         awburst,
  output logic               awvalid,
  input  logic               awready,
  // write data
  output logic [511:0]       wdata,
  output logic [63:0]        wstrb,
  output logic               wlast,
  output logic               wvalid,
  input  logic               wready,
  // write response
  input  logic [15:0]        bid,
  input  logic [1:0]         bresp,
  input  logic               bvalid,
  output logic               bready,
  // read address
  output logic [15:0]        arid,
  output logic [63:0]        araddr,
  output logic [7:0]         arlen,
  output logic [2:0]         arsize,
  output logic [1:0]         arburst,
  output logic               arvalid,
  input  logic               arready,
  // read data
  input  logic [15:0]        rid,
  input  logic [511:0]       rdata,
  input  logic [1:0]         rresp,
  input  logic               rlast,
  input  logic               rvalid,
  output logic               rready
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1) + 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        mode_q;
  logic [63:0]       base_q;
  logic [7:0]        len_q;
  logic [15:0]       nb_q;
  logic [31:0]       wval_q;

  // One address-issue engine serves AW in WR and AR in RD (phases are exclusive).
  logic              cmd_valid;
  logic [63:0]       cmd_addr, next_addr, stride;
  logic [15:0]       issued, cmp_cnt;
  logic [OW-1:0]     out_cnt, out_nxt, w_pend;
  logic [7:0]        w_beat, r_beat;
  logic [LAT_W-1:0]  ts, lat;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [LAT_W-1:0]  ts_mem [MAX_OUTSTANDING];

  logic accept, aw_fire, ar_fire, cmd_fire, w_fire, b_fire, r_fire, rl_fire;
  logic cmp_fire, last_cmp, wr_to_rd, can_issue;
  logic unused_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  assign accept   = start && (state == IDLE || state == DONE);
  assign aw_fire  = awvalid && awready;
  assign ar_fire  = arvalid && arready;
  assign cmd_fire = aw_fire || ar_fire;
  assign w_fire   = wvalid && wready;
  assign b_fire   = bvalid && bready;
  assign r_fire   = rvalid && rready;
  assign rl_fire  = r_fire && rlast;
  assign cmp_fire = b_fire || rl_fire;
  assign last_cmp = cmp_fire && (cmp_cnt == nb_q - 16'd1);
  assign wr_to_rd = (state == WR) && (state_nxt == RD);

  // Outstanding count after this cycle's events; gating on it keeps the
  // next valid from pushing in-flight bursts past the limit.
  assign out_nxt   = out_cnt + OW'(cmd_fire) - OW'(cmp_fire);
  assign can_issue = busy && !last_cmp && (issued < nb_q) &&
                     (out_nxt < OW'(MAX_OUTSTANDING));
  assign stride    = {49'd0, {1'b0, len_q} + 9'd1, 6'd0};
  assign lat       = ts - ts_mem[rd_ptr];

  assign busy    = (state == WR) || (state == RD);
  assign done    = (state == DONE);
  assign bready  = (state == WR);
  assign rready  = (state == RD);

  assign awid    = '0;
  assign awaddr  = cmd_addr;
  assign awlen   = len_q;
  assign awsize  = 3'b110;
  assign awburst = 2'b01;
  assign awvalid = cmd_valid && (state == WR);
  assign arid    = '0;
  assign araddr  = cmd_addr;
  assign arlen   = len_q;
  assign arsize  = 3'b110;
  assign arburst = 2'b01;
  assign arvalid = cmd_valid && (state == RD);

  assign wvalid  = (state == WR) && (w_pend != '0);
  assign wlast   = (w_beat == len_q);
  assign wstrb   = '1;

  assign unused_ok = ^{bid, rid, rdata[511:32]};

  always_comb begin
    wdata = '0;
    for (int i = 0; i < 16; i++) wdata[i*32 +: 32] = wval_q + {24'd0, w_beat};
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets its default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) begin
        if (num_bursts == 16'd0)              state_nxt = DONE;
        else if (mode == 2'd1 || mode == 2'd2) state_nxt = WR;
        else                                   state_nxt = RD;
      end
      WR:      if (last_cmp) state_nxt = (mode_q == 2'd2) ? RD : DONE;
      RD:      if (last_cmp) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= '0; base_q <= '0; len_q <= '0; nb_q <= '0; wval_q <= '0;
      cmd_valid <= 1'b0; cmd_addr <= '0; next_addr <= '0;
      issued <= '0; cmp_cnt <= '0; out_cnt <= '0; w_pend <= '0;
      w_beat <= '0; r_beat <= '0; ts <= '0; wr_ptr <= '0; rd_ptr <= '0;
      err <= 1'b0; rd_hash <= '0; rd_cycles <= '0; wr_cycles <= '0;
      max_rd_lat <= '0;
    end else begin
      ts <= ts + LAT_W'(1);

      if (accept) begin
        mode_q <= mode; base_q <= start_addr; len_q <= burst_len;
        nb_q <= num_bursts; wval_q <= write_val;
        err <= 1'b0; rd_hash <= '0; rd_cycles <= '0; wr_cycles <= '0;
        max_rd_lat <= '0;
      end else begin
        if (state == WR && wr_cycles != '1) wr_cycles <= wr_cycles + CNT_W'(1);
        if (state == RD && rd_cycles != '1) rd_cycles <= rd_cycles + CNT_W'(1);
        if (b_fire && bresp != 2'b00) err <= 1'b1;
        if (r_fire) begin
          rd_hash <= {rd_hash[30:0], rd_hash[31]} ^ rdata[31:0];
          if (rresp != 2'b00) err <= 1'b1;
          if (mode_q == 2'd2 && rdata[31:0] != wval_q + {24'd0, r_beat}) err <= 1'b1;
        end
        if (rl_fire && lat > max_rd_lat) max_rd_lat <= lat;
      end

      if (accept || wr_to_rd) begin
        cmd_valid <= 1'b0;
        next_addr <= accept ? start_addr : base_q;
        issued <= '0; cmp_cnt <= '0; out_cnt <= '0; w_pend <= '0;
        w_beat <= '0; r_beat <= '0; wr_ptr <= '0; rd_ptr <= '0;
      end else begin
        out_cnt <= out_nxt;
        if (cmp_fire) cmp_cnt <= cmp_cnt + 16'd1;
        if (!cmd_valid || cmd_fire) begin
          cmd_valid <= can_issue;
          if (can_issue) begin
            cmd_addr  <= next_addr;
            next_addr <= next_addr + stride;
            issued    <= issued + 16'd1;
          end
        end
        w_pend <= w_pend + OW'(aw_fire) - OW'(w_fire && wlast);
        if (w_fire)  w_beat <= wlast ? 8'd0 : w_beat + 8'd1;
        if (r_fire)  r_beat <= rlast ? 8'd0 : r_beat + 8'd1;
        if (ar_fire) wr_ptr <= ptr_inc(wr_ptr);
        if (rl_fire) rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  // NOTE: timestamp storage is not reset; the pointers alone define empty.
  always_ff @(posedge clk) begin
    if (ar_fire) ts_mem[wr_ptr] <= ts;
  end

endmodule

// File: tb/tb_dram_perf_gen.sv
// Directed bench for dram_perf_gen with a zero-wait echo-memory AXI slave
// that can stall R, corrupt a beat, or return an error response.
module tb_dram_perf_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [1:0]   mode = '0;
  logic [63:0]  start_addr = '0;
  logic [7:0]   burst_len = '0;
  logic [15:0]  num_bursts = '0;
  logic [31:0]  write_val = '0;
  logic         busy, done, err;
  logic [31:0]  rd_hash, rd_cycles, wr_cycles;
  logic [15:0]  max_rd_lat;

  logic [15:0]  awid, arid, bid, rid;
  logic [63:0]  awaddr, araddr, wstrb;
  logic [7:0]   awlen, arlen;
  logic [2:0]   awsize, arsize;
  logic [1:0]   awburst, arburst, bresp, rresp;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic [511:0] wdata, rdata;

  assign awready = 1'b1;
  assign wready  = 1'b1;
  assign arready = 1'b1;
  assign bid     = '0;
  assign rid     = '0;

  dram_perf_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .start_addr(start_addr),
    .burst_len(burst_len), .num_bursts(num_bursts), .write_val(write_val),
    .busy(busy), .done(done), .err(err), .rd_hash(rd_hash), .rd_cycles(rd_cycles),
    .wr_cycles(wr_cycles), .max_rd_lat(max_rd_lat),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  // ---------------- slave model ----------------
  typedef struct { logic [63:0] addr; logic [7:0] len; } rq_t;
  rq_t          ar_q[$];
  logic [63:0]  aw_q[$];
  logic [31:0]  mem [logic [63:0]];
  int           w_beat_s, r_beat_s, b_pend, rb_total, cyc;
  int           r_hold_until = 0;
  int           corrupt_at = -1;
  int           err_at = -1;
  logic [63:0]  sa;
  logic [31:0]  sd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_q.delete(); ar_q.delete();
      w_beat_s = 0; r_beat_s = 0; b_pend = 0;
      bvalid <= 1'b0; bresp <= 2'b00;
      rvalid <= 1'b0; rlast <= 1'b0; rdata <= '0; rresp <= 2'b00;
    end else begin
      cyc++;
      if (awvalid && awready) aw_q.push_back(awaddr);
      if (wvalid && wready && aw_q.size() > 0) begin
        mem[aw_q[0] + 64'(64 * w_beat_s)] = wdata[31:0];
        if (wlast) begin
          w_beat_s = 0; void'(aw_q.pop_front()); b_pend++;
        end else w_beat_s++;
      end
      if (bvalid && bready) b_pend--;
      bvalid <= (b_pend > 0);
      bresp  <= 2'b00;

      if (rvalid && rready) begin
        rb_total++;
        if (rlast) begin
          r_beat_s = 0;
          if (ar_q.size() > 0) void'(ar_q.pop_front());
        end else r_beat_s++;
      end
      if (arvalid && arready) ar_q.push_back('{araddr, arlen});
      if (!(rvalid && !rready)) begin
        if (ar_q.size() > 0 && cyc >= r_hold_until) begin
          sa = ar_q[0].addr + 64'(64 * r_beat_s);
          sd = mem.exists(sa) ? mem[sa] : sa[31:0];
          if (rb_total == corrupt_at) sd = sd ^ 32'h1;
          rvalid <= 1'b1;
          rdata  <= {480'd0, sd};
          rresp  <= (rb_total == err_at) ? 2'b10 : 2'b00;
          rlast  <= (8'(r_beat_s) == ar_q[0].len);
        end else rvalid <= 1'b0;
      end
    end
  end

  // ---------------- protocol monitor ----------------
  int           aw_cnt, w_cnt, ar_cnt, w_bad, a_bad, vld_cnt, outs, peak;
  int           mon_wb;
  logic [31:0]  wv_exp = '0;
  logic [7:0]   len_exp = '0;
  logic [31:0]  wexp;
  logic [63:0]  aw_log[$], ar_log[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      mon_wb = 0; outs = 0;
    end else begin
      if (awvalid || arvalid || wvalid) vld_cnt++;
      if (awvalid && awready) begin
        aw_cnt++; aw_log.push_back(awaddr);
        if (awlen != len_exp || awsize != 3'b110 || awburst != 2'b01 || awid != 0) a_bad++;
      end
      if (arvalid && arready) begin
        ar_cnt++; ar_log.push_back(araddr); outs++;
        if (outs > peak) peak = outs;
        if (arlen != len_exp || arsize != 3'b110 || arburst != 2'b01 || arid != 0) a_bad++;
      end
      if (rvalid && rready && rlast) outs--;
      if (wvalid && wready) begin
        w_cnt++;
        wexp = wv_exp + 32'(mon_wb);
        if (wdata[31:0] != wexp || wdata[511:480] != wexp || wstrb != '1 ||
            wlast != (8'(mon_wb) == len_exp)) w_bad++;
        mon_wb = wlast ? 0 : mon_wb + 1;
      end
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk); n++;
    end
    check(tag, 64'(done), 64'd1);
  endtask

  task automatic launch(input logic [1:0] m, input logic [63:0] a, input logic [7:0] l,
                        input logic [15:0] n, input logic [31:0] v);
    @(negedge clk);
    mode = m; start_addr = a; burst_len = l; num_bursts = n; write_val = v;
    wv_exp = v; len_exp = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [31:0] hstep(input logic [31:0] h, input logic [31:0] d);
    return {h[30:0], h[31]} ^ d;
  endfunction

  int aw0, w0, ar0, wb0, ab0, v0;
  logic [31:0] h;

  task automatic snap();
    aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt; wb0 = w_bad; ab0 = a_bad; v0 = vld_cnt;
  endtask

  initial begin
    // reset state
    #1;
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_err", 64'(err), 0);
    check("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 0);
    check("rst_hash", 64'(rd_hash), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_done", 64'(done), 0);

    // mode 1: four single-beat writes
    snap();
    launch(2'd1, 64'h1000, 8'd0, 16'd4, 32'hA5A5_0000);
    wait_done("t1_done", 200);
    check("t1_aw", 64'(aw_cnt - aw0), 4);
    check("t1_w", 64'(w_cnt - w0), 4);
    check("t1_wdata", 64'(w_bad - wb0), 0);
    check("t1_abits", 64'(a_bad - ab0), 0);
    check("t1_addr0", aw_log[aw0], 64'h1000);
    check("t1_addr3", aw_log[aw0+3], 64'h10C0);
    check("t1_err", 64'(err), 0);
    check("t1_wrcyc_ge5", 64'(wr_cycles >= 5), 1);
    check("t1_wrcyc", 64'(wr_cycles), 7);
    check("t1_rdcyc", 64'(rd_cycles), 0);
    check("t1_busy", 64'(busy), 0);

    // mode 2: write then verify, clean echo
    snap();
    launch(2'd2, 64'h2000, 8'd3, 16'd2, 32'h1000);
    wait_done("t2_done", 300);
    h = '0;
    for (int k = 0; k < 8; k++) h = hstep(h, 32'h1000 + 32'(k % 4));
    check("t2_err", 64'(err), 0);
    check("t2_w", 64'(w_cnt - w0), 8);
    check("t2_wdata", 64'(w_bad - wb0), 0);
    check("t2_ar", 64'(ar_cnt - ar0), 2);
    check("t2_araddr1", ar_log[ar0+1], 64'h2100);
    check("t2_hash", 64'(rd_hash), 64'(h));
    check("t2_maxlat", 64'(max_rd_lat), 7);
    check("t2_rdcyc_nz", 64'(rd_cycles != 0), 1);

    // mode 2 with one corrupted read beat
    corrupt_at = rb_total + 5;
    launch(2'd2, 64'h2000, 8'd3, 16'd2, 32'h1000);
    wait_done("t3_done", 300);
    corrupt_at = -1;
    check("t3_err", 64'(err), 1);

    // mode 0: 20 reads behind a long R stall
    snap();
    r_hold_until = cyc + 110;
    launch(2'd0, 64'h40000, 8'd0, 16'd20, 32'h0);
    wait_done("t4_done", 1000);
    h = '0;
    for (int k = 0; k < 20; k++) h = hstep(h, 32'h40000 + 32'(64 * k));
    check("t4_ar", 64'(ar_cnt - ar0), 20);
    check("t4_peak", 64'(peak), 8);
    check("t4_lat_ge100", 64'(max_rd_lat >= 100), 1);
    check("t4_hash", 64'(rd_hash), 64'(h));
    check("t4_araddr19", ar_log[ar0+19], 64'h404C0);
    check("t4_abits", 64'(a_bad - ab0), 0);
    check("t4_wrcyc", 64'(wr_cycles), 0);
    check("t4_err", 64'(err), 0);

    // start while busy is ignored
    snap();
    launch(2'd1, 64'h3000, 8'd1, 16'd2, 32'h77);
    check("t6_busy", 64'(busy), 1);
    @(negedge clk);
    mode = 2'd0; num_bursts = 16'd5; write_val = 32'hDEAD; start_addr = 64'h9000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t6_done", 200);
    check("t6_aw", 64'(aw_cnt - aw0), 2);
    check("t6_ar", 64'(ar_cnt - ar0), 0);
    check("t6_wdata", 64'(w_bad - wb0), 0);
    check("t6_rdcyc", 64'(rd_cycles), 0);

    // mode 3 with an error response on one beat
    err_at = rb_total + 2;
    launch(2'd3, 64'h80000, 8'd1, 16'd3, 32'h0);
    wait_done("t7_done", 200);
    err_at = -1;
    h = '0;
    for (int k = 0; k < 6; k++) h = hstep(h, 32'h80000 + 32'(64 * k));
    check("t7_err", 64'(err), 1);
    check("t7_hash", 64'(rd_hash), 64'(h));

    // num_bursts=0 from DONE: results cleared, done next cycle
    snap();
    launch(2'd0, 64'h0, 8'd0, 16'd0, 32'h0);
    check("t5a_done", 64'(done), 1);
    check("t5a_err", 64'(err), 0);
    check("t5a_hash", 64'(rd_hash), 0);
    check("t5a_lat", 64'(max_rd_lat), 0);
    check("t5a_rdcyc", 64'(rd_cycles), 0);

    // reset asserted mid-write
    launch(2'd1, 64'h5000, 8'd7, 16'd10, 32'h55);
    repeat (3) @(negedge clk);
    check("t8_midburst", 64'(awvalid || wvalid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t8_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 0);
    check("t8_busy", 64'(busy), 0);
    check("t8_done", 64'(done), 0);
    check("t8_err", 64'(err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t8_idle", 64'({busy, done}), 0);

    // num_bursts=0 from IDLE: done exactly one cycle after start, no valids
    snap();
    launch(2'd2, 64'h0, 8'd0, 16'd0, 32'h0);
    check("t5b_done", 64'(done), 1);
    check("t5b_busy", 64'(busy), 0);
    repeat (3) @(negedge clk);
    check("t5b_novalid", 64'(vld_cnt - v0), 0);
    check("t5b_wrcyc", 64'(wr_cycles), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
